// File: rtl/div_8by4_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_8by4_seq
// Purpose  : Sequential restoring divider, 8-bit dividend / 4-bit divisor,
//            one quotient bit per cycle behind a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module div_8by4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  // Partial remainder kept at 4 bits: it is always below the divisor, so the
  // fifth bit of the 5-bit trial value never needs to be stored.
  logic [3:0] r;
  logic [7:0] q_r;
  logic [3:0] d_r;
  logic [2:0] cnt;

  logic       accept;
  logic       last_iter;
  logic [4:0] trial;
  logic       fits;
  logic [3:0] r_next;
  logic [7:0] q_next;

  assign accept    = start && (state != RUN);
  assign last_iter = (cnt == 3'd7);

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  // When the trial fits, trial - d_r < 16, so a 4-bit subtraction is exact.
  always_comb begin
    trial  = {r, q_r[7]};
    fits   = (trial >= {1'b0, d_r});
    r_next = trial[3:0];
    q_next = {q_r[6:0], 1'b0};
    if (fits) begin
      r_next = trial[3:0] - d_r;
      q_next = {q_r[6:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs; DONE accepts a new request like IDLE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (accept) state_next = (divisor == 4'd0) ? DONE : RUN;
        else        state_next = IDLE;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers updated on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= 4'd0;
      q_r       <= 8'd0;
      d_r       <= 4'd0;
      cnt       <= 3'd0;
      quotient  <= 8'd0;
      remainder <= 4'd0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      q_r      <= dividend;
      d_r      <= divisor;
      r        <= 4'd0;
      cnt      <= 3'd0;
      div_zero <= 1'b0;
      if (divisor == 4'd0) begin
        quotient  <= 8'hFF;
        remainder <= 4'hF;
        div_zero  <= 1'b1;
      end
    end else if (state == RUN) begin
      r   <= r_next;
      q_r <= q_next;
      cnt <= cnt + 3'd1;
      if (last_iter) begin
        quotient  <= q_next;
        remainder <= r_next;
        div_zero  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
